// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - BorrowIn, LSB first, with start/busy/done handshake
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BorrowIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             BorrowOut,
    output logic             Overflow
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             a_msb, b_msb, br;
    logic [CW-1:0]    cnt;
    logic             diff, br_next, last;

    assign diff    = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last    = cnt == CW'(WIDTH - 1);

    // next-state: accept from IDLE only, finish on the MSB, DONE lasts one cycle
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? SHIFT : IDLE;
            SHIFT:   state_next = last ? DONE : SHIFT;
            default: state_next = IDLE;
        endcase
    end

    // state register with busy/done registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= state_next == SHIFT;
            done  <= state_next == DONE;
        end
    end

    // datapath: latch operands on accept, ripple one bit per cycle, publish on the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            br        <= 1'b0;
            cnt       <= '0;
            D         <= '0;
            BorrowOut <= 1'b0;
            Overflow  <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh  <= A;
            b_sh  <= B;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
            br    <= BorrowIn;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            res  <= {diff, res[WIDTH-1:1]};
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            br   <= br_next;
            cnt  <= cnt + 1'b1;
            if (last) begin
                D         <= {diff, res[WIDTH-1:1]};
                BorrowOut <= br_next;
                Overflow  <= (a_msb != b_msb) && (diff != a_msb);
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       BorrowIn = 1'b0;
    logic       busy, done, BorrowOut, Overflow;
    logic [3:0] D;
    int         tests = 0;
    int         fails = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .BorrowIn(BorrowIn),
        .busy(busy), .done(done), .D(D), .BorrowOut(BorrowOut), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    // {Overflow, BorrowOut, D} from plain integer arithmetic
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic bi);
        int u, s;
        logic [3:0] dd;
        u  = int'(a) - int'(b) - int'(bi);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
        dd = u[3:0];
        return {(s < -8) || (s > 7), u < 0, dd};
    endfunction

    // runs one operation; returns at the negedge where done is seen (or after a timeout)
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                         output int lat, output logic bz);
        @(negedge clk);
        A = a; B = b; BorrowIn = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 4'($urandom); B = 4'($urandom); BorrowIn = 1'($urandom);
        lat = 0;
        bz  = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) bz = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy) bz = 1'b0;
    endtask

    task automatic test_reset();
        logic bad;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, D, BorrowOut, Overflow} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 00000000", {busy, done, D, BorrowOut, Overflow});
        end
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL idle_quiet: busy/done rose with start=0, required both 0");
        end
    endtask

    task automatic test_directed();
        logic [3:0] va [5] = '{4'b0101, 4'b0011, 4'b0111, 4'b1000, 4'b0000};
        logic [3:0] vb [5] = '{4'b0011, 4'b0101, 4'b1000, 4'b0001, 4'b0000};
        logic       vi [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [5:0] ex [5] = '{6'b00_0010, 6'b01_1110, 6'b11_1111, 6'b10_0111, 6'b01_1111};
        int lat;
        logic bz;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vi[i], lat, bz);
            tests++;
            if ({Overflow, BorrowOut, D} !== ex[i] || lat != 4 || !bz) begin
                fails++;
                $display("FAIL directed_%0d: got ov,bo,d=%b lat=%0d busy_ok=%b required %b lat=4 busy_ok=1",
                         i, {Overflow, BorrowOut, D}, lat, bz, ex[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        logic bi, bz;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom); b = 4'($urandom); bi = 1'($urandom);
            do_op(a, b, bi, lat, bz);
            tests++;
            if ({Overflow, BorrowOut, D} !== model(a, b, bi) || lat != 4 || !bz) begin
                fails++;
                $display("FAIL random %b-%b-%b: got %b lat=%0d required %b lat=4",
                         a, b, bi, {Overflow, BorrowOut, D}, lat, model(a, b, bi));
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic bad;
        @(negedge clk);
        A = 4'b0101; B = 4'b0011; BorrowIn = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 4'b1111; B = 4'b0001; BorrowIn = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if ({Overflow, BorrowOut, D} !== 6'b00_0010 || lat != 5) begin
            fails++;
            $display("FAIL ignore_start: got %b after %0d cycles required 000010 after 5",
                     {Overflow, BorrowOut, D}, lat);
        end
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy || done) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL start_not_queued: busy/done after ignored start, required idle");
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a1, b1, a2, b2, held;
        int dq[$];
        logic both, hold_bad, r1, r2;
        a1 = 4'($urandom); b1 = 4'($urandom); a2 = ~a1; b2 = 4'($urandom);
        both = 1'b0; hold_bad = 1'b0; r1 = 1'b0; r2 = 1'b0;
        @(negedge clk);
        A = a1; B = b1; BorrowIn = 1'b0; start = 1'b1;
        held = D;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin A = a2; B = b2; end
            if (busy && done) both = 1'b1;
            if (done) begin
                dq.push_back(c);
                if (c == 4) r1 = {Overflow, BorrowOut, D} === model(a1, b1, 1'b0);
                if (c == 10) r2 = {Overflow, BorrowOut, D} === model(a2, b2, 1'b0);
                held = D;
            end else if (D !== held) hold_bad = 1'b1;
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (dq.size() != 3 || dq[0] != 4 || dq[1] != 10 || dq[2] != 16) begin
            fails++;
            $display("FAIL b2b_spacing: done at %p required cycles 4,10,16", dq);
        end
        tests++;
        if (!r1 || !r2 || both || hold_bad) begin
            fails++;
            $display("FAIL b2b_results: first_ok=%b second_ok=%b busy&done=%b d_moved=%b required 1 1 0 0",
                     r1, r2, both, hold_bad);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        logic bz, bad;
        do_op(4'b0101, 4'b0011, 1'b0, lat, bz);
        @(negedge clk);
        A = 4'b1000; B = 4'b0001; BorrowIn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, D, BorrowOut, Overflow} !== 8'h00) begin
            fails++;
            $display("FAIL reset_midop_async: got %b required 00000000", {busy, done, D, BorrowOut, Overflow});
        end
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) bad = 1'b1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_midop_no_done: done/busy seen after abort, required 0");
        end
        do_op(4'b1000, 4'b0001, 1'b0, lat, bz);
        tests++;
        if ({Overflow, BorrowOut, D} !== 6'b10_0111 || lat != 4) begin
            fails++;
            $display("FAIL after_reset_op: got %b lat=%0d required 100111 lat=4", {Overflow, BorrowOut, D}, lat);
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] v;
        logic [3:0] a, b;
        logic bi, bz;
        int lat;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            a = v[8:5]; b = v[4:1]; bi = v[0];
            do_op(a, b, bi, lat, bz);
            $display("%b - %b - %b = %b, %b | %b", a, b, bi, D, BorrowOut, Overflow);
            tests++;
            if ({Overflow, BorrowOut, D} !== model(a, b, bi) || lat != 4) begin
                fails++;
                $display("FAIL exhaustive %b-%b-%b: got %b lat=%0d required %b lat=4",
                         a, b, bi, {Overflow, BorrowOut, D}, lat, model(a, b, bi));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
